// File: rtl/door_lock_ctrl_if.sv
// Key-path handshake between the keypad deserializer and the door lock controller.
// The deserializer presents one decoded key byte per strobe; the controller answers
// with a one-cycle start pulse when it is ready for the next key.
interface door_lock_ctrl_if #(
  parameter int KEY_W = 8
) ();
  logic             i_key_valid;
  logic [KEY_W-1:0] i_key_data;
  logic             o_start;

  modport master (
    output i_key_valid,
    output i_key_data,
    input  o_start
  );

  modport slave (
    input  i_key_valid,
    input  i_key_data,
    output o_start
  );
endinterface

// File: rtl/door_lock_ctrl.sv
// Keypad door lock sequencer: assembles CODE_LEN key bytes, compares them with the
// stored code and drives the lock/unlock/error/timeout/lockout indicators, with
// per-key idle timeout, consecutive-failure counting and a lockout period.
// Optional build macro CODE_PROG_EN adds a PROG state (entered with '#' while
// unlocked) that replaces the stored code; without it the code is fixed.
module door_lock_ctrl #(
  parameter int                        CODE_LEN     = 4,
  parameter int                        KEY_W        = 8,
  parameter logic [CODE_LEN*KEY_W-1:0] DEFAULT_CODE = 32'h31323334,
  parameter int                        KEY_TIMEOUT  = 1000,
  parameter int                        UNLOCK_HOLD  = 5000,
  parameter int                        ERR_HOLD     = 500,
  parameter int                        MAX_TRIES    = 3,
  parameter int                        LOCKOUT_CYC  = 20000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  door_lock_ctrl_if.slave                keyIf,
  input  logic                           i_lock_cmd,
  output logic                           o_locked,
  output logic                           o_unlocked,
  output logic                           o_error,
  output logic                           o_timeout,
  output logic                           o_lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0] o_fail_cnt
);

  localparam int CODE_W = CODE_LEN * KEY_W;
  localparam int IDX_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int T_A    = (KEY_TIMEOUT > ERR_HOLD) ? KEY_TIMEOUT : ERR_HOLD;
  localparam int T_MAX  = (T_A > LOCKOUT_CYC) ? T_A : LOCKOUT_CYC;
  localparam int TMR_W  = $clog2(T_MAX + 1);
  localparam int HOLD_W = $clog2(UNLOCK_HOLD + 1);

  localparam logic [KEY_W-1:0] KEY_STAR = KEY_W'(8'h2A);
`ifdef CODE_PROG_EN
  localparam logic [KEY_W-1:0] KEY_HASH = KEY_W'(8'h23);
`endif

  typedef enum logic [2:0] {
    LOCKED,
    ENTRY,
    CHECK,
    ERROR,
    UNLOCKED,
    LOCKOUT
`ifdef CODE_PROG_EN
    , PROG
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [HOLD_W-1:0]  holdTimer_q, holdTimer_d;
  logic [CODE_W-1:0]  codeBuf_q, codeBuf_d;
  logic [FAIL_W-1:0]  failCnt_q, failCnt_d;
  logic [FAIL_W-1:0]  failNext;
  logic [CODE_W-1:0]  refCode;
  logic               startPending_q;
  logic               start_q, locked_q, unlocked_q, error_q, timeout_q, lockout_q;
  logic               keyAccept, timeoutHit, unlockedNext;
  logic               keyValid;
  logic [KEY_W-1:0]   keyData;
  logic [CODE_W-1:0]  shiftedCode;

`ifdef CODE_PROG_EN
  logic [CODE_W-1:0]  storedCode_q, storedCode_d;
  assign refCode = storedCode_q;
`else
  assign refCode = DEFAULT_CODE;
`endif

  assign keyValid    = keyIf.i_key_valid;
  assign keyData     = keyIf.i_key_data;
  assign shiftedCode = (codeBuf_q << KEY_W) | CODE_W'(keyData);

  // Next-state logic: key handling, timers, code compare and failure accounting.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    holdTimer_d  = holdTimer_q;
    codeBuf_d    = codeBuf_q;
    failCnt_d    = failCnt_q;
    failNext     = failCnt_q;
    keyAccept    = 1'b0;
    timeoutHit   = 1'b0;
    unlockedNext = 1'b0;
`ifdef CODE_PROG_EN
    storedCode_d = storedCode_q;
`endif
    case (state_q)
      LOCKED: begin
        if (keyValid && keyData != KEY_STAR) begin
          keyAccept = 1'b1;
          codeBuf_d = CODE_W'(keyData);
          idx_d     = IDX_W'(1);
          timer_d   = '0;
          state_d   = (CODE_LEN == 1) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (keyValid) begin
          keyAccept = 1'b1;
          timer_d   = '0;
          if (keyData == KEY_STAR) begin
            codeBuf_d = '0;
            idx_d     = '0;
            state_d   = LOCKED;
          end else begin
            codeBuf_d = shiftedCode;
            if (idx_q == IDX_W'(CODE_LEN - 1)) begin
              idx_d   = '0;
              state_d = CHECK;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end else if (timer_q == TMR_W'(KEY_TIMEOUT - 1)) begin
          timeoutHit = 1'b1;
          codeBuf_d  = '0;
          idx_d      = '0;
          timer_d    = '0;
          state_d    = LOCKED;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      CHECK: begin
        timer_d     = '0;
        holdTimer_d = '0;
        codeBuf_d   = '0;
        if (codeBuf_q == refCode) begin
          failCnt_d = '0;
          state_d   = UNLOCKED;
        end else begin
          if (failCnt_q != FAIL_W'(MAX_TRIES)) begin
            failNext = failCnt_q + FAIL_W'(1);
          end
          failCnt_d = failNext;
          state_d   = (failNext == FAIL_W'(MAX_TRIES)) ? LOCKOUT : ERROR;
        end
      end
      ERROR: begin
        if (timer_q == TMR_W'(ERR_HOLD - 1)) begin
          timer_d = '0;
          state_d = LOCKED;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      UNLOCKED: begin
        if (i_lock_cmd) begin
          holdTimer_d = '0;
          state_d     = LOCKED;
`ifdef CODE_PROG_EN
        end else if (keyValid && keyData == KEY_HASH) begin
          keyAccept = 1'b1;
          idx_d     = '0;
          timer_d   = '0;
          codeBuf_d = '0;
          state_d   = PROG;
`endif
        end else if (holdTimer_q == HOLD_W'(UNLOCK_HOLD - 1)) begin
          holdTimer_d = '0;
          state_d     = LOCKED;
        end else begin
          holdTimer_d = holdTimer_q + HOLD_W'(1);
        end
      end
      LOCKOUT: begin
        if (timer_q == TMR_W'(LOCKOUT_CYC - 1)) begin
          timer_d   = '0;
          failCnt_d = '0;
          state_d   = LOCKED;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
`ifdef CODE_PROG_EN
      PROG: begin
        if (i_lock_cmd) begin
          idx_d       = '0;
          timer_d     = '0;
          holdTimer_d = '0;
          codeBuf_d   = '0;
          state_d     = LOCKED;
        end else if (keyValid) begin
          keyAccept = 1'b1;
          timer_d   = '0;
          if (keyData == KEY_STAR) begin
            idx_d     = '0;
            codeBuf_d = '0;
            state_d   = UNLOCKED;
          end else if (idx_q == IDX_W'(CODE_LEN - 1)) begin
            storedCode_d = shiftedCode;
            holdTimer_d  = '0;
            idx_d        = '0;
            codeBuf_d    = '0;
            state_d      = UNLOCKED;
          end else begin
            codeBuf_d = shiftedCode;
            idx_d     = idx_q + IDX_W'(1);
          end
        end else if (timer_q == TMR_W'(KEY_TIMEOUT - 1)) begin
          timeoutHit = 1'b1;
          idx_d      = '0;
          timer_d    = '0;
          codeBuf_d  = '0;
          state_d    = UNLOCKED;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
`endif
      default: state_d = LOCKED;
    endcase
    unlockedNext = (state_d == UNLOCKED);
`ifdef CODE_PROG_EN
    if (state_d == PROG) unlockedNext = 1'b1;
`endif
  end

  // State, entry buffer, timers and failure count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOCKED;
      idx_q       <= '0;
      timer_q     <= '0;
      holdTimer_q <= '0;
      codeBuf_q   <= '0;
      failCnt_q   <= '0;
`ifdef CODE_PROG_EN
      storedCode_q <= DEFAULT_CODE;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      holdTimer_q <= holdTimer_d;
      codeBuf_q   <= codeBuf_d;
      failCnt_q   <= failCnt_d;
`ifdef CODE_PROG_EN
      storedCode_q <= storedCode_d;
`endif
    end
  end

  // Registered indicators, derived from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startPending_q <= 1'b1;
      start_q        <= 1'b0;
      locked_q       <= 1'b1;
      unlocked_q     <= 1'b0;
      error_q        <= 1'b0;
      timeout_q      <= 1'b0;
      lockout_q      <= 1'b0;
    end else begin
      startPending_q <= 1'b0;
      start_q        <= startPending_q | keyAccept;
      locked_q       <= !unlockedNext;
      unlocked_q     <= unlockedNext;
      error_q        <= (state_d == ERROR) || (state_d == LOCKOUT);
      timeout_q      <= timeoutHit;
      lockout_q      <= (state_d == LOCKOUT);
    end
  end

  assign keyIf.o_start = start_q;
  assign o_locked      = locked_q;
  assign o_unlocked    = unlocked_q;
  assign o_error       = error_q;
  assign o_timeout     = timeout_q;
  assign o_lockout     = lockout_q;
  assign o_fail_cnt    = failCnt_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed-plus-random bench for door_lock_ctrl. Expected behaviour comes from a
// small model of the lock rules (stored code, consecutive failure count) and the
// fixed hold/timeout durations; all outputs are sampled 1 time unit after posedge.
module tb_door_lock_ctrl;

  localparam int          KEY_W        = 8;
  localparam int          CODE_LEN     = 4;
  localparam logic [31:0] DEFAULT_CODE = 32'h31323334;
  localparam int          KEY_TIMEOUT  = 1000;
  localparam int          UNLOCK_HOLD  = 5000;
  localparam int          ERR_HOLD     = 500;
  localparam int          MAX_TRIES    = 3;
  localparam int          LOCKOUT_CYC  = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lockCmd;
  logic       locked, unlocked, errorInd, timeoutInd, lockoutInd;
  logic [1:0] failCnt;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int timeoutPulses = 0;
  logic [31:0] refCode = DEFAULT_CODE;
  int refFail = 0;

  door_lock_ctrl_if #(.KEY_W(KEY_W)) keyBus ();

  door_lock_ctrl #(
    .CODE_LEN(CODE_LEN), .KEY_W(KEY_W), .DEFAULT_CODE(DEFAULT_CODE),
    .KEY_TIMEOUT(KEY_TIMEOUT), .UNLOCK_HOLD(UNLOCK_HOLD), .ERR_HOLD(ERR_HOLD),
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keyIf(keyBus), .i_lock_cmd(lockCmd),
    .o_locked(locked), .o_unlocked(unlocked), .o_error(errorInd),
    .o_timeout(timeoutInd), .o_lockout(lockoutInd), .o_fail_cnt(failCnt)
  );

  always #5 clk = ~clk;

  // Count timeout pulses mid-cycle so single-pulse behaviour can be verified.
  always @(negedge clk) begin
    if (timeoutInd === 1'b1) timeoutPulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag, input logic expLocked, input logic expUnlocked,
                             input logic expError, input logic expLockout);
    checkOutput(tag, 32'({locked, unlocked, errorInd, lockoutInd}),
                32'({expLocked, expUnlocked, expError, expLockout}));
  endtask

  task automatic sendKey(input logic [7:0] k);
    keyBus.i_key_valid = 1'b1;
    keyBus.i_key_data  = k;
    tick();
    keyBus.i_key_valid = 1'b0;
    keyBus.i_key_data  = 8'($urandom);
  endtask

  function automatic logic [31:0] randomDigits();
    logic [31:0] c;
    for (int i = 0; i < CODE_LEN; i++) c[8*i +: 8] = 8'h30 + 8'($urandom_range(9, 0));
    return c;
  endfunction

  function automatic logic [31:0] randomWrong(input logic [31:0] good);
    logic [31:0] c;
    c = randomDigits();
    if (c == good) c[7:0] = (c[7:0] == 8'h39) ? 8'h30 : c[7:0] + 8'h01;
    return c;
  endfunction

  // Send one code, first key first, with random short idle gaps between keys.
  task automatic applyStimulus(input logic [31:0] code, input int gapMax);
    for (int i = 0; i < CODE_LEN; i++) begin
      repeat ($urandom_range(gapMax, 0)) tick();
      sendKey(code[31 - 8*i -: 8]);
      checkOutput("o_start after key", 32'(keyBus.o_start), 32'd1);
    end
  endtask

  // Enter a code from LOCKED and check the verdict against the model.
  task automatic submitCode(input logic [31:0] code, input string tag, input int gapMax);
    applyStimulus(code, gapMax);
    checkStatus({tag, " check cycle"}, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    if (code == refCode) begin
      refFail = 0;
      checkStatus({tag, " unlocked"}, 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      refFail = refFail + 1;
      if (refFail == MAX_TRIES) checkStatus({tag, " lockout"}, 1'b1, 1'b0, 1'b1, 1'b1);
      else checkStatus({tag, " error"}, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    checkOutput({tag, " fail count"}, 32'(failCnt), 32'(refFail));
  endtask

  task automatic relock(input string tag);
    repeat ($urandom_range(20, 1)) tick();
    lockCmd = 1'b1;
    tick();
    lockCmd = 1'b0;
    checkStatus(tag, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int lockStart;
    int pulsesBefore;
    int nStar;

    rst_n = 1'b0;
    lockCmd = 1'b0;
    keyBus.i_key_valid = 1'b0;
    keyBus.i_key_data = '0;
    repeat (3) tick();
    checkStatus("reset status", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset o_start", 32'(keyBus.o_start), 32'd0);
    checkOutput("reset o_timeout", 32'(timeoutInd), 32'd0);
    checkOutput("reset fail count", 32'(failCnt), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("start after reset", 32'(keyBus.o_start), 32'd1);
    tick();
    checkOutput("start single pulse", 32'(keyBus.o_start), 32'd0);

    $display("[TB] correct code and unlock hold");
    submitCode(DEFAULT_CODE, "good code", 4);
    repeat (UNLOCK_HOLD - 1) tick();
    checkStatus("unlock hold end", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkStatus("auto relock", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] wrong codes, error hold, lockout");
    submitCode(randomWrong(refCode), "wrong 1", 4);
    repeat (ERR_HOLD - 1) tick();
    checkStatus("error hold end", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkStatus("error released", 1'b1, 1'b0, 1'b0, 1'b0);
    submitCode(randomWrong(refCode), "wrong 2", 4);
    repeat (ERR_HOLD) tick();
    submitCode(randomWrong(refCode), "wrong 3", 4);
    lockStart = cyc;
    for (int i = 0; i < CODE_LEN; i++) begin
      sendKey(refCode[31 - 8*i -: 8]);
      checkOutput("no start in lockout", 32'(keyBus.o_start), 32'd0);
    end
    repeat (3) tick();
    checkStatus("keys ignored in lockout", 1'b1, 1'b0, 1'b1, 1'b1);
    lockCmd = 1'b1;
    tick();
    lockCmd = 1'b0;
    while (cyc < lockStart + LOCKOUT_CYC - 1) tick();
    checkStatus("lockout end", 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("fail count in lockout", 32'(failCnt), 32'd3);
    tick();
    refFail = 0;
    checkStatus("lockout released", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fail count after lockout", 32'(failCnt), 32'(refFail));

    $display("[TB] key timeout");
    pulsesBefore = timeoutPulses;
    sendKey(8'h31);
    sendKey(8'h32);
    repeat (KEY_TIMEOUT - 1) tick();
    checkOutput("no timeout yet", 32'(timeoutInd), 32'd0);
    tick();
    checkOutput("timeout pulse", 32'(timeoutInd), 32'd1);
    checkStatus("timeout to locked", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fail unchanged by timeout", 32'(failCnt), 32'(refFail));
    tick();
    checkOutput("timeout pulse count", 32'(timeoutPulses - pulsesBefore), 32'd1);
    submitCode(refCode, "code after timeout", 2);
    relock("relock cmd 1");

    $display("[TB] key on terminal count");
    pulsesBefore = timeoutPulses;
    sendKey(8'h31);
    repeat (KEY_TIMEOUT - 1) tick();
    sendKey(8'h32);
    sendKey(8'h33);
    sendKey(8'h34);
    tick();
    checkStatus("terminal key unlock", 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("no timeout on terminal key", 32'(timeoutPulses - pulsesBefore), 32'd0);
    relock("relock cmd 2");

    $display("[TB] star clears entry");
    nStar = $urandom_range(3, 1);
    for (int i = 0; i < nStar; i++) sendKey(8'h30 + 8'($urandom_range(9, 0)));
    sendKey(8'h2A);
    tick();
    checkStatus("star back to locked", 1'b1, 1'b0, 1'b0, 1'b0);
    submitCode(refCode, "code after star", 3);
    checkOutput("fail after star", 32'(failCnt), 32'd0);
    relock("relock cmd 3");

    $display("[TB] reset during entry");
    submitCode(randomWrong(refCode), "wrong before reset", 2);
    repeat (ERR_HOLD) tick();
    sendKey(8'h31);
    sendKey(8'h32);
    #2;
    rst_n = 1'b0;
    #1;
    checkStatus("reset in entry", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset in entry fail", 32'(failCnt), 32'd0);
    checkOutput("reset in entry start", 32'(keyBus.o_start), 32'd0);
    refFail = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("start after entry reset", 32'(keyBus.o_start), 32'd1);
    tick();

    $display("[TB] reset during lockout");
    for (int i = 0; i < MAX_TRIES; i++) begin
      submitCode(randomWrong(refCode), "wrong for reset", 3);
      if (i < MAX_TRIES - 1) repeat (ERR_HOLD) tick();
    end
    repeat ($urandom_range(50, 5)) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkStatus("reset in lockout", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset in lockout fail", 32'(failCnt), 32'd0);
    checkOutput("reset in lockout timeout", 32'(timeoutInd), 32'd0);
    refFail = 0;
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("start after lockout reset", 32'(keyBus.o_start), 32'd1);
    tick();
    submitCode(refCode, "code after lockout reset", 3);
    relock("relock cmd 4");

`ifdef CODE_PROG_EN
    $display("[TB] code programming");
    submitCode(refCode, "unlock for prog", 3);
    sendKey(8'h23);
    checkOutput("start after hash", 32'(keyBus.o_start), 32'd1);
    checkStatus("prog keeps unlocked", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h35363738, 3);
    checkStatus("prog done", 1'b0, 1'b1, 1'b0, 1'b0);
    refCode = 32'h35363738;
    relock("relock after prog");
    submitCode(DEFAULT_CODE, "old code rejected", 3);
    repeat (ERR_HOLD) tick();
    submitCode(refCode, "new code accepted", 3);
    relock("relock new code");
    #2;
    rst_n = 1'b0;
    #1;
    refCode = DEFAULT_CODE;
    refFail = 0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    submitCode(refCode, "default restored", 3);
    relock("relock default");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
